// File: rtl/cpu8bit_mem_pkg.sv
// Shared types and default sizing for the CPU data-memory bus master.
package cpu8bit_mem_pkg;

    localparam int unsigned AW_DEF     = 4;
    localparam int unsigned DW_DEF     = 8;
    localparam int unsigned RD_LAT_DEF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    // Counter spans 0..RD_LAT inclusive.
    function automatic int unsigned cnt_width(input int unsigned rd_lat);
        return (rd_lat < 1) ? 1 : $clog2(rd_lat + 1);
    endfunction

endpackage

// File: rtl/mem_bus_master.sv
// Bus master bridging CPU load/store requests onto the data memory's
// address/strobe lines and shared tri-state data bus.
module mem_bus_master
    import cpu8bit_mem_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          done_o,
    output logic [DW-1:0] rdata_o,
    output logic          busy_o,
    output logic [AW-1:0] mem_add_o,
    output logic          mem_r_o,
    output logic          mem_w_o,
    inout  wire  [DW-1:0] mem_data_io
);

    localparam int unsigned   CW       = cnt_width(RD_LAT);
    localparam logic [CW-1:0] CNT_LAST = CW'(RD_LAT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          ready_q;
    logic          done_q, done_d;
    logic          r_q;
    logic          w_q;
    logic          accept;
    logic          rd_capture;

    assign accept = req_valid_i & ready_q;

    // Next-state, read-latency counter and completion decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        rd_capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = req_we_i ? WRITE : READ;
                end
            end
            WRITE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            READ: begin
                if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    rd_capture = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes and ready are registered from the next state so they are
    // glitch-free and stable for the whole transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            r_q     <= 1'b0;
            w_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ready_q <= (state_d == IDLE);
            r_q     <= (state_d == READ);
            w_q     <= (state_d == WRITE);
            if (accept) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            if (rd_capture) begin
                rdata_q <= mem_data_io;
            end
        end
    end

    assign req_ready_o = ready_q;
    assign busy_o      = ~ready_q;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign mem_add_o   = addr_q;
    assign mem_r_o     = r_q;
    assign mem_w_o     = w_q;

    // Bus is released whenever no write is in progress.
    assign mem_data_io = w_q ? wdata_q : {DW{1'bz}};

endmodule
